reg_alu_sequencer: RTL and testbench

Multicycle execute/write-back sequencer that sits directly downstream of the 16x16 register file's read ports and upstream of its write port. It accepts one three-address instruction at a time (op, dst, srcA, srcB) and drives the file's A/B read addresses. It latches the operands, computes a 16-bit ALU result with Zero/Carry flags, and issues a single-cycle write of the result back to the file. It closes the read-compute-write loop around the register file for the lab datapath.

---
 rtl/reg_alu_sequencer.sv | 120 ++++++++++++
 tb/tb_reg_alu_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_alu_sequencer.sv
// Four-state execute/write-back sequencer wrapped around a 16x16 register file:
// read operands, compute ALU result + Zero/Carry, issue a one-cycle write-back.
module reg_alu_sequencer #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             InstrValid,
  output logic             InstrReady,
  input  logic [2:0]       Opcode,
  input  logic [AW-1:0]    DstAddr,
  input  logic [AW-1:0]    SrcAAddr,
  input  logic [AW-1:0]    SrcBAddr,
  output logic [AW-1:0]    Aaddr,
  output logic [AW-1:0]    Baddr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [AW-1:0]    Caddr,
  output logic             Load,
  output logic             Done,
  output logic             Zero,
  output logic             Carry
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010,
                         OP_OR  = 3'b011, OP_XOR = 3'b100, OP_SHL = 3'b101,
                         OP_SHR = 3'b110, OP_MOV = 3'b111;

  state_t           r_state;
  logic [2:0]       r_op;
  logic [AW-1:0]    r_dst, r_srca, r_srcb, r_caddr;
  logic [WIDTH-1:0] r_opa, r_opb, r_result;
  logic             r_zero, r_carry;

  logic [WIDTH-1:0] w_res;
  logic             w_cy;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH:0]   w_sum, w_diff, w_shl, w_shr;

  // Shifts are done one bit wider so the bit shifted out lands in the extra position.
  assign w_sh   = r_opb[SHW-1:0];
  assign w_sum  = {1'b0, r_opa} + {1'b0, r_opb};
  assign w_diff = {1'b0, r_opa} - {1'b0, r_opb};
  assign w_shl  = {1'b0, r_opa} << w_sh;
  assign w_shr  = {r_opa, 1'b0} >> w_sh;

  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    unique case (r_op)
      OP_ADD: {w_cy, w_res} = w_sum;
      OP_SUB: {w_cy, w_res} = w_diff;
      OP_AND: w_res = r_opa & r_opb;
      OP_OR:  w_res = r_opa | r_opb;
      OP_XOR: w_res = r_opa ^ r_opb;
      OP_SHL: {w_cy, w_res} = w_shl;
      OP_SHR: {w_res, w_cy} = w_shr;
      OP_MOV: w_res = r_opa;
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_dst    <= '0;
      r_srca   <= '0;
      r_srcb   <= '0;
      r_caddr  <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (InstrValid) begin
          r_op    <= Opcode;
          r_dst   <= DstAddr;
          r_srca  <= SrcAAddr;
          r_srcb  <= SrcBAddr;
          r_state <= S_READ;
        end
        S_READ: begin
          r_opa   <= A;
          r_opb   <= B;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_result <= w_res;
          r_zero   <= (w_res == '0);
          r_carry  <= w_cy;
          r_caddr  <= r_dst;
          r_state  <= S_WRITE;
        end
        S_WRITE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Handshake and write strobes are forced low combinationally while reset is held.
  assign InstrReady = (r_state == S_IDLE)  && !reset;
  assign Load       = (r_state == S_WRITE) && !reset;
  assign Done       = Load;
  assign Aaddr      = r_srca;
  assign Baddr      = r_srcb;
  assign C          = r_result;
  assign Caddr      = r_caddr;
  assign Zero       = r_zero;
  assign Carry      = r_carry;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Directed bench for reg_alu_sequencer with a behavioural 16x16 register file
// closing the read/write loop.
module tb_reg_alu_sequencer;

  logic        Clk = 1'b0;
  logic        reset, InstrValid, InstrReady;
  logic [2:0]  Opcode;
  logic [3:0]  DstAddr, SrcAAddr, SrcBAddr, Aaddr, Baddr, Caddr;
  logic [15:0] A, B, C;
  logic        Load, Done, Zero, Carry;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] rf [16];
  logic        pw;
  logic [3:0]  pa;
  logic [15:0] pd;

  always #5 Clk = ~Clk;

  always @(posedge Clk) begin
    if (Load) rf[Caddr] <= C;
    else if (pw) rf[pa] <= pd;
  end
  assign A = rf[Aaddr];
  assign B = rf[Baddr];

  reg_alu_sequencer #(.WIDTH(16), .AW(4)) dut (
    .Clk(Clk), .reset(reset), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Opcode(Opcode), .DstAddr(DstAddr), .SrcAAddr(SrcAAddr), .SrcBAddr(SrcBAddr),
    .Aaddr(Aaddr), .Baddr(Baddr), .A(A), .B(B), .C(C), .Caddr(Caddr),
    .Load(Load), .Done(Done), .Zero(Zero), .Carry(Carry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [15:0] d);
    @(negedge Clk);
    pw = 1'b1; pa = a; pd = d;
    @(posedge Clk);
    #1 pw = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] sa,
                       input logic [3:0] sb);
    @(negedge Clk);
    chk("ready_before_issue", InstrReady, 1);
    InstrValid = 1'b1; Opcode = op; DstAddr = dst; SrcAAddr = sa; SrcBAddr = sb;
    @(posedge Clk);
    #1 InstrValid = 1'b0;
  endtask

  // n0 = number of post-accept negedges already consumed by the caller.
  task automatic wait_load(input string tag, input int n0, input logic [15:0] ec,
                           input logic [3:0] ea, input logic ez, input logic ecy);
    int n;
    n = n0;
    do begin
      @(negedge Clk);
      n++;
    end while (!Load && n < 12);
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_C"}, C, ec);
    chk({tag, "_Caddr"}, Caddr, ea);
    chk({tag, "_Zero"}, Zero, ez);
    chk({tag, "_Carry"}, Carry, ecy);
    chk({tag, "_Done"}, Done, 1);
    @(negedge Clk);
    chk({tag, "_ready_after"}, InstrReady, 1);
    chk({tag, "_load_after"}, Load, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, loads;
    reset = 1'b1; InstrValid = 1'b0; Opcode = '0; DstAddr = '0; SrcAAddr = '0;
    SrcBAddr = '0; pw = 1'b0; pa = '0; pd = '0;
    repeat (2) @(negedge Clk);
    chk("rst_ready", InstrReady, 0);
    chk("rst_load", Load, 0);
    chk("rst_done", Done, 0);
    reset = 1'b0;
    #1;
    chk("rst_ready_rel", InstrReady, 1);
    chk("rst_aaddr", Aaddr, 0);
    chk("rst_baddr", Baddr, 0);
    chk("rst_C", C, 0);
    chk("rst_caddr", Caddr, 0);
    chk("rst_zero", Zero, 0);
    chk("rst_carry", Carry, 0);

    // Basic ADD
    preload(1, 16'h0003); preload(2, 16'h0005); preload(9, 16'h0007);
    issue(3'b000, 3, 1, 2);
    wait_load("add", 0, 16'h0008, 3, 0, 0);
    chk("add_rf3", rf[3], 16'h0008);

    // InstrValid pulsed during READ with other fields must be ignored
    issue(3'b000, 3, 1, 2);
    @(negedge Clk);
    InstrValid = 1'b1; Opcode = 3'b001; DstAddr = 14; SrcAAddr = 9; SrcBAddr = 9;
    chk("ign_aaddr", Aaddr, 1);
    @(negedge Clk);
    InstrValid = 1'b0;
    chk("ign_baddr", Baddr, 2);
    wait_load("ign", 2, 16'h0008, 3, 0, 0);

    // Dependent back-to-back with InstrValid held high
    @(negedge Clk);
    InstrValid = 1'b1; Opcode = 3'b000; DstAddr = 3; SrcAAddr = 1; SrcBAddr = 2;
    @(posedge Clk);
    #1 DstAddr = 7; SrcAAddr = 3; SrcBAddr = 3;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      if (n == 3) chk("dep_first_C", C, 16'h0008);
    end while (!InstrReady && n < 12);
    chk("dep_gap", n, 4);
    @(posedge Clk);
    #1 InstrValid = 1'b0;
    wait_load("dep", 0, 16'h0010, 7, 0, 0);
    chk("dep_rf7", rf[7], 16'h0010);

    // Shifts
    preload(1, 16'h8001); preload(6, 16'h0001); preload(8, 16'h0000);
    issue(3'b101, 10, 1, 6);
    wait_load("shl1", 0, 16'h0002, 10, 0, 1);
    issue(3'b110, 11, 1, 6);
    wait_load("shr1", 0, 16'h4000, 11, 0, 1);
    issue(3'b101, 12, 1, 8);
    wait_load("shl0", 0, 16'h8001, 12, 0, 0);
    issue(3'b110, 12, 1, 8);
    wait_load("shr0", 0, 16'h8001, 12, 0, 0);

    // Logic ops and MOV
    preload(10, 16'h0F0F); preload(11, 16'h00FF);
    issue(3'b010, 12, 10, 11);
    wait_load("and", 0, 16'h000F, 12, 0, 0);
    issue(3'b011, 12, 10, 11);
    wait_load("or", 0, 16'h0FFF, 12, 0, 0);
    issue(3'b100, 12, 10, 11);
    wait_load("xor", 0, 16'h0FF0, 12, 0, 0);
    issue(3'b111, 12, 10, 11);
    wait_load("mov", 0, 16'h0F0F, 12, 0, 0);

    // Carry-out and borrow
    preload(1, 16'hFFFF); preload(2, 16'h0001);
    issue(3'b000, 4, 1, 2);
    wait_load("addc", 0, 16'h0000, 4, 1, 1);
    issue(3'b001, 5, 2, 1);
    wait_load("subb", 0, 16'h0002, 5, 0, 1);

    // Reset during EXEC abandons the instruction
    preload(13, 16'h1234);
    issue(3'b000, 13, 1, 2);
    @(negedge Clk);
    @(negedge Clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", InstrReady, 0);
    chk("mid_rst_load", Load, 0);
    @(negedge Clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready_rel", InstrReady, 1);
    chk("mid_rst_C", C, 0);
    chk("mid_rst_caddr", Caddr, 0);
    chk("mid_rst_aaddr", Aaddr, 0);
    chk("mid_rst_carry", Carry, 0);
    chk("mid_rst_zero", Zero, 0);
    loads = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (Load) loads++;
    end
    chk("mid_rst_noload", loads, 0);
    chk("mid_rst_rf13", rf[13], 16'h1234);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
